// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the writeback queue.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Occupancy needs one extra bit so that a completely full queue is representable.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_match.sv
// Scans the queued entries oldest-to-youngest for a destination match on one read address.
// With WB_FORWARD_EN defined it also returns the data of the youngest matching entry.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t               entries_i [DEPTH],
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [ADDR_W-1:0]       addr_i,
  output logic                    hit_o
`ifdef WB_FORWARD_EN
  ,
  output logic [DATA_W-1:0]       data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walking from the head means a later match overwrites an earlier one, so the youngest wins.
  always_comb begin
    hit_o = 1'b0;
    idx   = head_i;
`ifdef WB_FORWARD_EN
    data_o = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].dest == addr_i)) begin
        hit_o = 1'b1;
`ifdef WB_FORWARD_EN
        data_o = entries_i[idx].data;
`endif
      end
    end
  end

`ifndef WB_FORWARD_EN
  logic [DEPTH-1:0] unusedData;

  always_comb begin
    unusedData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      unusedData[k] = ^entries_i[k].data;
    end
  end
`endif

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue in front of the register file, fed by the ALU and load paths.
// Optional macro WB_FORWARD_EN adds youngest-match data outputs fwd1_data/fwd2_data.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [ADDR_W-1:0]        wDest,
  output logic [DATA_W-1:0]        wDat,
  output logic                     regWrt,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef WB_FORWARD_EN
  ,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;
  logic             accAlu, accMem;
  logic [PTR_W-1:0] memSlot;
  logic [PTR_W-1:0] offs;
  logic [DEPTH-1:0] validMask;

  // Readiness looks only at registered occupancy; a slot freed by this cycle's pop is not reused.
  assign free      = CNT_W'(DEPTH) - count_q;
  assign alu_ready = (free >= CNT_W'(1));
  assign mem_ready = alu_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));
  assign accAlu    = alu_valid & alu_ready;
  assign accMem    = mem_valid & mem_ready;

  assign regWrt = (count_q != '0);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign wDest  = regWrt ? entries_q[head_q].dest : '0;
  assign wDat   = regWrt ? entries_q[head_q].data : '0;

  // The ALU entry is older, so the load entry lands behind it when both are taken.
  always_comb begin
    memSlot = tail_q + PTR_W'(accAlu);
    head_d  = head_q + PTR_W'(regWrt);
    tail_d  = tail_q + PTR_W'(accAlu) + PTR_W'(accMem);
    count_d = count_q + CNT_W'(accAlu) + CNT_W'(accMem) - CNT_W'(regWrt);
  end

  always_comb begin
    validMask = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PTR_W'(i) - head_q;
      validMask[i] = (CNT_W'(offs) < count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (accAlu) begin
        entries_q[tail_q] <= wb_entry_t'{dest: alu_dest, data: alu_data};
      end
      if (accMem) begin
        entries_q[memSlot] <= wb_entry_t'{dest: mem_dest, data: mem_data};
      end
    end
  end

  wb_match #(.DEPTH(DEPTH)) uMatch1 (
    .entries_i (entries_q),
    .valid_i   (validMask),
    .head_i    (head_q),
    .addr_i    (rd_addr1),
    .hit_o     (pend1)
`ifdef WB_FORWARD_EN
    ,
    .data_o    (fwd1_data)
`endif
  );

  wb_match #(.DEPTH(DEPTH)) uMatch2 (
    .entries_i (entries_q),
    .valid_i   (validMask),
    .head_i    (head_q),
    .addr_i    (rd_addr2),
    .hit_o     (pend2)
`ifdef WB_FORWARD_EN
    ,
    .data_o    (fwd2_data)
`endif
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: a per-cycle vector table plus reset and full-queue sequences.
module tb_wb_write_queue;

  logic        clk;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_dest, mem_dest;
  logic [15:0] alu_data, mem_data;
  logic [2:0]  wDest;
  logic [15:0] wDat;
  logic        regWrt;
  logic [2:0]  rd_addr1, rd_addr2;
  logic        pend1, pend2;
  logic [2:0]  count;
  logic        full, empty;
`ifdef WB_FORWARD_EN
  logic [15:0] fwd1_data, fwd2_data;
  logic [15:0] fwd1b, fwd2b;
`endif

  logic        a2Valid, m2Valid, a2Ready, m2Ready;
  logic [2:0]  a2Dest, m2Dest, w2Dest;
  logic [15:0] a2Data, m2Data, w2Dat;
  logic        w2Wrt, p2a, p2b, full2, empty2;
  logic [1:0]  count2;
  logic [2:0]  rdZero;

  int total;
  int bad;

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .wDest(wDest), .wDat(wDat), .regWrt(regWrt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2),
    .count(count), .full(full), .empty(empty)
`ifdef WB_FORWARD_EN
    , .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  wb_write_queue #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .alu_valid(a2Valid), .alu_ready(a2Ready), .alu_dest(a2Dest), .alu_data(a2Data),
    .mem_valid(m2Valid), .mem_ready(m2Ready), .mem_dest(m2Dest), .mem_data(m2Data),
    .wDest(w2Dest), .wDat(w2Dat), .regWrt(w2Wrt),
    .rd_addr1(rdZero), .rd_addr2(rdZero), .pend1(p2a), .pend2(p2b),
    .count(count2), .full(full2), .empty(empty2)
`ifdef WB_FORWARD_EN
    , .fwd1_data(fwd1b), .fwd2_data(fwd2b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [2:0]  ad;
    logic [15:0] adat;
    logic        mv;
    logic [2:0]  md;
    logic [15:0] mdat;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        eAR;
    logic        eMR;
    logic        eWrt;
    logic [2:0]  eDest;
    logic [15:0] eDat;
    logic [2:0]  eCnt;
    logic        eP1;
    logic        eP2;
  } vec_t;

  vec_t vecs [26];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av;
    alu_dest  = v.ad;
    alu_data  = v.adat;
    mem_valid = v.mv;
    mem_dest  = v.md;
    mem_data  = v.mdat;
    rd_addr1  = v.r1;
    rd_addr2  = v.r2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rdZero = 3'd0;
    a2Valid = 0; a2Dest = 0; a2Data = 0;
    m2Valid = 0; m2Dest = 0; m2Data = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    rd_addr1 = 0; rd_addr2 = 0;

    //        av ad adat     mv md mdat     r1 r2 aR mR wr dst dat     cnt p1 p2
    vecs[0]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[1]  = '{1, 3, 16'h5,    0, 0, 16'h0,    3, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[2]  = '{0, 0, 16'h0,    0, 0, 16'h0,    3, 0, 1, 1, 1, 3, 16'h5,    1, 1, 0};
    vecs[3]  = '{0, 0, 16'h0,    0, 0, 16'h0,    3, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[4]  = '{1, 1, 16'd10,   1, 2, 16'd20,   0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[5]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 1, 16'd10,   2, 0, 0};
    vecs[6]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 2, 16'd20,   1, 0, 0};
    vecs[7]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[8]  = '{1, 4, 16'h41,   1, 5, 16'h51,   0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[9]  = '{1, 6, 16'h61,   1, 7, 16'h71,   0, 0, 1, 1, 1, 4, 16'h41,   2, 0, 0};
    vecs[10] = '{1, 1, 16'h12,   1, 2, 16'h22,   0, 0, 1, 0, 1, 5, 16'h51,   3, 0, 0};
    vecs[11] = '{0, 0, 16'h0,    1, 2, 16'h22,   0, 0, 1, 1, 1, 6, 16'h61,   3, 0, 0};
    vecs[12] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 7, 16'h71,   3, 0, 0};
    vecs[13] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 1, 16'h12,   2, 0, 0};
    vecs[14] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 2, 16'h22,   1, 0, 0};
    vecs[15] = '{1, 5, 16'h55,   1, 7, 16'h77,   5, 6, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[16] = '{0, 0, 16'h0,    0, 0, 16'h0,    5, 6, 1, 1, 1, 5, 16'h55,   2, 1, 0};
    vecs[17] = '{0, 0, 16'h0,    0, 0, 16'h0,    5, 7, 1, 1, 1, 7, 16'h77,   1, 0, 1};
    vecs[18] = '{0, 0, 16'h0,    0, 0, 16'h0,    5, 7, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[19] = '{1, 0, 16'hAAAA, 1, 0, 16'hBBBB, 0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[20] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 0, 16'hAAAA, 2, 1, 1};
    vecs[21] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 1, 0, 16'hBBBB, 1, 1, 1};
    vecs[22] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[23] = '{0, 0, 16'h0,    1, 6, 16'h66,   6, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};
    vecs[24] = '{0, 0, 16'h0,    0, 0, 16'h0,    6, 0, 1, 1, 1, 6, 16'h66,   1, 1, 0};
    vecs[25] = '{0, 0, 16'h0,    0, 0, 16'h0,    6, 0, 1, 1, 0, 0, 16'h0,    0, 0, 0};

    // Reset held for 10 ns; outputs must already be in their idle state.
    reset = 1'b1;
    #2;
    checkOutput("rst_regWrt", regWrt, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_wDest", wDest, 0);
    checkOutput("rst_wDat", wDat, 0);
    checkOutput("rst_empty2", empty2, 1);
    #8;
    reset = 1'b0;
    nextCycle();

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].eAR);
      checkOutput($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].eMR);
      checkOutput($sformatf("v%0d_regWrt", i), regWrt, vecs[i].eWrt);
      checkOutput($sformatf("v%0d_wDest", i), wDest, vecs[i].eDest);
      checkOutput($sformatf("v%0d_wDat", i), wDat, vecs[i].eDat);
      checkOutput($sformatf("v%0d_count", i), count, vecs[i].eCnt);
      checkOutput($sformatf("v%0d_pend1", i), pend1, vecs[i].eP1);
      checkOutput($sformatf("v%0d_pend2", i), pend2, vecs[i].eP2);
      checkOutput($sformatf("v%0d_empty", i), empty, (vecs[i].eCnt == 3'd0));
      checkOutput($sformatf("v%0d_full", i), full, (vecs[i].eCnt == 3'd4));
      nextCycle();
    end

`ifdef WB_FORWARD_EN
    // Two writes to r5 in flight: forwarding must pick the younger one.
    alu_valid = 1; alu_dest = 5; alu_data = 16'h11;
    mem_valid = 1; mem_dest = 5; mem_data = 16'h22;
    rd_addr1 = 5; rd_addr2 = 6;
    nextCycle();
    alu_valid = 0; mem_valid = 0;
    #1;
    checkOutput("fwd_youngest", fwd1_data, 16'h22);
    checkOutput("fwd_pend1", pend1, 1);
    checkOutput("fwd_nomatch", fwd2_data, 16'h0);
    nextCycle();
    nextCycle();
    checkOutput("fwd_drained", fwd1_data, 16'h0);
`endif

    // Build three queued entries, then pulse reset between edges.
    alu_valid = 1; alu_dest = 1; alu_data = 16'h1;
    mem_valid = 1; mem_dest = 2; mem_data = 16'h2;
    rd_addr1 = 3; rd_addr2 = 4;
    nextCycle();
    alu_dest = 3; alu_data = 16'h3;
    mem_dest = 4; mem_data = 16'h4;
    nextCycle();
    alu_valid = 0; mem_valid = 0;
    #1;
    checkOutput("mid_count_pre", count, 3);
    checkOutput("mid_wDest_pre", wDest, 2);
    checkOutput("mid_pend1_pre", pend1, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_regWrt", regWrt, 0);
    checkOutput("mid_count", count, 0);
    checkOutput("mid_empty", empty, 1);
    checkOutput("mid_wDest", wDest, 0);
    checkOutput("mid_wDat", wDat, 0);
    checkOutput("mid_pend1", pend1, 0);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput($sformatf("post_rst%0d_regWrt", c), regWrt, 0);
      checkOutput($sformatf("post_rst%0d_count", c), count, 0);
    end

    // DEPTH=2 instance: a dual enqueue from empty fills it.
    a2Valid = 1; a2Dest = 1; a2Data = 16'h31;
    m2Valid = 1; m2Dest = 2; m2Data = 16'h32;
    #1;
    checkOutput("d2_alu_ready0", a2Ready, 1);
    checkOutput("d2_mem_ready0", m2Ready, 1);
    nextCycle();
    m2Valid = 0;
    a2Dest = 3; a2Data = 16'h33;
    #1;
    checkOutput("d2_full", full2, 1);
    checkOutput("d2_alu_ready_full", a2Ready, 0);
    checkOutput("d2_count_full", count2, 2);
    checkOutput("d2_wDest_full", w2Dest, 1);
    nextCycle();
    #1;
    checkOutput("d2_alu_ready_drain", a2Ready, 1);
    checkOutput("d2_full_drain", full2, 0);
    checkOutput("d2_count_drain", count2, 1);
    checkOutput("d2_wDest_drain", w2Dest, 2);
    nextCycle();
    a2Valid = 0;
    #1;
    checkOutput("d2_wDest_held", w2Dest, 3);
    checkOutput("d2_wDat_held", w2Dat, 16'h33);
    checkOutput("d2_count_held", count2, 1);
    nextCycle();
    checkOutput("d2_empty_end", empty2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
